// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2,
    DBL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Number of address bits selecting a byte lane within one memory word.
  function automatic int unsigned lane_bits(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment: load extraction/extension, store merge and misalignment detect.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned LB     = lane_bits(DATA_W)
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [LB-1:0]     off_i,
  input  size_e             size_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] ld_ext_c_o,
  output logic [DATA_W-1:0] st_word_c_o,
  output logic              misalign_c_o
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] rd_sh;
  logic [DATA_W-1:0] wd_sh;
  logic              sgn_bit;
  int unsigned       nbytes;
  int unsigned       off;

  always_comb begin
    rd_sh   = word_i >> {off_i, 3'b000};
    wd_sh   = wdata_i << {off_i, 3'b000};
    nbytes  = 32'd1 << size_i;
    off     = 32'(off_i);
    sgn_bit = 1'b0;
    case (size_i)
      BYTE:    sgn_bit = rd_sh[7];
      HALF:    sgn_bit = rd_sh[15];
      WORD:    sgn_bit = rd_sh[31];
      DBL:     sgn_bit = rd_sh[DATA_W-1];
      default: sgn_bit = 1'b0;
    endcase
    sgn_bit     = sgn_bit & signed_i;
    ld_ext_c_o  = '0;
    st_word_c_o = word_i;
    // Lanes inside the access window come from the shifted data; others extend or keep.
    for (int unsigned b = 0; b < NB; b++) begin
      ld_ext_c_o[8*b +: 8] = (b < nbytes) ? rd_sh[8*b +: 8] : {8{sgn_bit}};
      if ((b >= off) && (b < off + nbytes)) begin
        st_word_c_o[8*b +: 8] = wd_sh[8*b +: 8];
      end
    end
    misalign_c_o = |(off_i & LB'(nbytes - 32'd1));
  end

endmodule

// File: rtl/dmem_bytelane_ctrl.sv
// MEM-stage data memory: sized loads/stores, fixed access latency, one request in flight.
module dmem_bytelane_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LATENCY      = 2,
  parameter bit          INIT_PATTERN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int unsigned LB     = lane_bits(DATA_W);
  localparam int unsigned MEM_AW = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(LATENCY + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  size_e               size_q, size_d;
  logic                sgn_q, sgn_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [ADDR_W-LB-1:0] word_idx;
  logic [MEM_AW-1:0]    mem_idx;
  logic                 out_of_range;
  logic                 size_bad;
  logic                 misalign;
  logic                 acc_err;
  logic                 mem_we_c;
  logic [DATA_W-1:0]    pattern;
  logic [DATA_W-1:0]    rd_word;
  logic [DATA_W-1:0]    ld_ext;
  logic [DATA_W-1:0]    st_word;

  assign word_idx     = addr_q[ADDR_W-1:LB];
  assign mem_idx      = word_idx[MEM_AW-1:0];
  assign out_of_range = |(word_idx >> MEM_AW);
  assign size_bad     = (DATA_W == 32) && (size_q == DBL);
  assign acc_err      = size_bad | misalign | out_of_range;

  // The array holds data XOR its initial pattern, so power-up zero contents read as the pattern.
  assign pattern = INIT_PATTERN ? DATA_W'(mem_idx) : '0;
  assign rd_word = mem_q[mem_idx] ^ pattern;

  dmem_lane_align #(.DATA_W(DATA_W)) u_align (
    .word_i       (rd_word),
    .off_i        (addr_q[LB-1:0]),
    .size_i       (size_q),
    .signed_i     (sgn_q),
    .wdata_i      (wdata_q),
    .ld_ext_c_o   (ld_ext),
    .st_word_c_o  (st_word),
    .misalign_c_o (misalign)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          size_d  = size_e'(req_size_i);
          sgn_d   = req_signed_i;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (acc_err || we_q) ? '0 : ld_ext;
          mem_we_c    = we_q & ~acc_err;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= BYTE;
      sgn_q       <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_idx] <= st_word ^ pattern;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_bytelane_ctrl.sv
// Self-checking bench: directed vector table, reset corner cases, random accesses vs a byte-array model.
module tb_dmem_bytelane_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        v4, rdy4, we4, sg4, rsp4, err4;
  logic [31:0] addr4, wd4, rd4;
  logic [1:0]  sz4;

  int checks;
  int failures;

  logic [7:0] bmem [0:1023];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    bit          sgn;
    bit          eerr;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs[$];

  dmem_bytelane_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_signed_i(req_signed),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  dmem_bytelane_ctrl #(.LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(v4), .req_ready_o(rdy4), .req_we_i(we4),
    .req_addr_i(addr4), .req_wdata_i(wd4), .req_size_i(sz4),
    .req_signed_i(sg4),
    .rsp_valid_o(rsp4), .rsp_rdata_o(rd4), .rsp_err_o(err4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: memory as a flat little-endian byte array, DEPTH*4 bytes.
  function automatic void model(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [1:0] sz, input bit sg,
                                output bit err, output logic [31:0] rd);
    int unsigned n;
    logic [63:0] v;
    n   = 32'd1 << sz;
    rd  = '0;
    err = (sz == 2'd3) || ((addr % n) != 0) || (addr >= 32'd1024);
    if (err) return;
    if (we) begin
      for (int i = 0; i < int'(n); i++) bmem[addr + 32'(i)] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < int'(n); i++) v[8*i +: 8] = bmem[addr + 32'(i)];
      if (sg && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      rd = v[31:0];
    end
  endfunction

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input bit sg,
                        output bit err, output logic [31:0] rd);
    int n;
    @(negedge clk);
    chk("ready_idle", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wd;
    req_size   = sz;
    req_signed = sg;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom_range(0, 1));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_size   = 2'($urandom_range(0, 3));
    req_signed = 1'($urandom_range(0, 1));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("ready_busy", 64'(req_ready), 64'd0);
    end while (!rsp_valid && n < 20);
    chk("latency", 64'(n), 64'd3);
    err = rsp_err;
    rd  = rsp_rdata;
    @(negedge clk);
    chk("pulse_len", 64'(rsp_valid), 64'd0);
    chk("ready_back", 64'(req_ready), 64'd1);
  endtask

  initial begin
    bit          e, me;
    logic [31:0] r, mr, a, wd;
    logic [1:0]  sz;
    bit          we, sg;
    int          n, last, acc, pulses;
    bit          prev;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = 2'd0; req_signed = 1'b0;
    v4 = 1'b0; we4 = 1'b0; addr4 = '0; wd4 = '0; sz4 = 2'd0; sg4 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bmem[4*i]   = 8'(i);
      bmem[4*i+1] = 8'(i >> 8);
      bmem[4*i+2] = 8'd0;
      bmem[4*i+3] = 8'd0;
    end

    vecs.push_back('{1'b0, 32'h10, 32'h0,    2'd2, 1'b0, 1'b0, 32'h00000004});
    vecs.push_back('{1'b1, 32'h22, 32'hBEEF, 2'd1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h22, 32'h0,    2'd1, 1'b1, 1'b0, 32'hFFFFBEEF});
    vecs.push_back('{1'b0, 32'h22, 32'h0,    2'd1, 1'b0, 1'b0, 32'h0000BEEF});
    vecs.push_back('{1'b0, 32'h20, 32'h0,    2'd2, 1'b0, 1'b0, 32'hBEEF0008});
    vecs.push_back('{1'b1, 32'h0D, 32'h80,   2'd0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0D, 32'h0,    2'd0, 1'b1, 1'b0, 32'hFFFFFF80});
    vecs.push_back('{1'b0, 32'h0D, 32'h0,    2'd0, 1'b0, 1'b0, 32'h00000080});
    vecs.push_back('{1'b0, 32'h0C, 32'h0,    2'd2, 1'b0, 1'b0, 32'h00008003});
    vecs.push_back('{1'b0, 32'h06, 32'h0,    2'd2, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h400, 32'h12345678, 2'd2, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0,  32'h0,    2'd2, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h08, 32'h0,    2'd3, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h21, 32'h0,    2'd1, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h3FC, 32'h0,   2'd2, 1'b0, 1'b0, 32'h000000FF});

    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    rst_n = 1'b1;

    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid || !req_ready) n++;
    end
    chk("idle_quiet", 64'(n), 64'd0);

    foreach (vecs[i]) begin
      model(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].sgn, me, mr);
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].sgn, e, r);
      chk($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].eerr));
      chk($sformatf("vec%0d_rdata", i), 64'(r), 64'(vecs[i].erd));
      chk($sformatf("vec%0d_model", i), 64'(r), 64'(mr));
    end

    // Reset during BUSY discards the pending store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    req_size = 2'd2; req_signed = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy_ready", 64'(req_ready), 64'd1);
    chk("rst_busy_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, e, r);
    chk("rst_busy_load", 64'(r), 64'h10);

    // Reset during RESP: store already committed, valid drops at once.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h44; req_wdata = 32'h12345678;
    req_size = 2'd2; req_signed = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    chk("resp_seen", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model(1'b1, 32'h44, 32'h12345678, 2'd2, 1'b0, me, mr);
    access(1'b0, 32'h44, 32'h0, 2'd2, 1'b0, e, r);
    chk("rst_resp_load", 64'(r), 64'h12345678);

    for (int t = 0; t < 150; t++) begin
      sz = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 1099));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if (t % 25 == 7) a = $urandom;
      wd = $urandom;
      model(we, a, wd, sz, sg, me, mr);
      access(we, a, wd, sz, sg, e, r);
      chk($sformatf("rand%0d_err a=%0h sz=%0d", t, a, sz), 64'(e), 64'(me));
      chk($sformatf("rand%0d_rdata a=%0h sz=%0d", t, a, sz), 64'(r), 64'(mr));
    end

    // LATENCY=4 instance with request held high: one accept every 6 cycles.
    @(negedge clk);
    v4 = 1'b1; we4 = 1'b0; addr4 = 32'h10; sz4 = 2'd2; sg4 = 1'b0; wd4 = '0;
    last = -1; acc = 0; pulses = 0; prev = 1'b0;
    for (int k = 0; k < 62; k++) begin
      if (rsp4) begin
        pulses++;
        chk("l4_single", 64'(prev), 64'd0);
        chk("l4_rdata", 64'(rd4), 64'd4);
      end
      prev = rsp4;
      if (rdy4 && v4) begin
        if (last >= 0) chk("l4_gap", 64'(k - last), 64'd6);
        last = k;
        acc++;
      end
      @(negedge clk);
    end
    v4 = 1'b0;
    chk("l4_accepts", 64'(acc), 64'd11);
    chk("l4_pulses", 64'(pulses), 64'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_bytelane_ctrl.md
# dmem_bytelane_ctrl

Parametrised data memory for the pipeline's MEM stage. It replaces the fixed 256×32 word-only memory with configurable width, depth and access latency. It adds byte/half/word(/double) loads and stores with sign or zero extension, a valid/ready request handshake, and error reporting for misaligned or out-of-range accesses. One request is in flight at a time; the hazard unit stalls MEM while `req_ready` is low.

## Interface
- `DATA_W`, 32: word width; 32 or 64 only.
- `DEPTH`, 256: number of words; power of two, ≥ 4.
- `ADDR_W`, 32: byte-address width.
- `LATENCY`, 2: cycles from acceptance to response; ≥ 1.
- `INIT_PATTERN`, 1: 1 → word i initialised to i at time zero; 0 → all zero.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept; reset 1.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data, right-aligned.
- `req_size` in 2: 0 byte, 1 half, 2 word, 3 double.
- `req_signed` in 1: loads only; 1 = sign-extend.
- `rsp_valid` out 1: one-cycle response pulse; reset 0.
- `rsp_rdata` out DATA_W: load result; 0 for stores and errors; reset 0.
- `rsp_err` out 1: access rejected; reset 0.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset → IDLE.
- `req_ready` = (state == IDLE).
- IDLE: on `req_valid & req_ready`, latch all request fields, load counter = LATENCY−1, go to BUSY.
- BUSY: decrement the counter each cycle. When the counter is 0, go to RESP. On that same edge, commit any store and register `rsp_rdata`/`rsp_err`.
- RESP: `rsp_valid` = 1 for exactly one cycle, then go to IDLE. Outputs clear to 0 on leaving RESP.
- Lane offset = `addr[log2(DATA_W/8)−1:0]`. Word index = `addr >> log2(DATA_W/8)`.
- Error (`rsp_err` = 1, no write, `rsp_rdata` = 0) under any of these conditions:
  - size=3 with DATA_W=32.
  - Size misaligned to the lane offset (half with odd offset; word with offset[1:0]≠0; double with offset≠0).
  - Word index ≥ DEPTH.
- Load: extract 2^size bytes starting at the lane offset, little-endian. Zero- or sign-extend to DATA_W per `req_signed`.
- Store: read-modify-write of only the addressed byte lanes, using the low bytes of `req_wdata`. Other lanes are unchanged.
- The memory array is never cleared by reset. Only the FSM, counter, latched request and outputs are reset.

## Timing
- Acceptance at edge N puts `rsp_valid` high during the cycle following edge N+LATENCY.
- The earliest next acceptance is edge N+LATENCY+2, so throughput is one access per LATENCY+2 cycles.
- A store is visible to a load accepted at any later edge.
- `req_valid` low in IDLE leaves the block idle; no spurious response is produced.
- Request inputs change freely after acceptance, because all fields are latched.
- Reset asserted in BUSY: FSM → IDLE and the pending store is discarded (it has not committed). Reset asserted in RESP: the store is already committed, and `rsp_valid` drops immediately.

## Structure
- Package `dmem_pkg` holds:
  - the `size_e` enum (BYTE, HALF, WORD, DBL);
  - the `state_e` enum (IDLE, BUSY, RESP);
  - the `lane_bits(DATA_W)` helper.
- Sub-module `dmem_lane_align` is purely combinational. It takes word, offset, size, signed flag and store data, and produces the extended load value, merged store word, and misalignment flag.
- The top module holds the FSM, counter, array and range check.

## Test plan
- Reset, then load word at 0x10 with the default pattern → `req_ready` drops one cycle; `rsp_valid` appears after 2 cycles with `rsp_rdata` = 0x00000004, `rsp_err` = 0.
- Store half 0xBEEF at 0x22, then signed load half at 0x22 → 0xFFFFBEEF. A word load at 0x20 → 0xBEEF0008.
- Store byte 0x80 at 0x0D, then load byte at 0x0D → signed 0xFFFFFF80, unsigned 0x00000080. Word 0x0C reads 0x00008003.
- Word load at 0x06 → `rsp_err` = 1, `rsp_rdata` = 0. Word store at 0x400 (DEPTH=256) → `rsp_err` = 1 and memory unchanged.
- LATENCY=4: hold `req_valid` high continuously → exactly one acceptance per 6 cycles; each `rsp_valid` is a single-cycle pulse.
- Store word 0xDEADBEEF at 0x40, pulling `rst_n` low during BUSY → then load 0x40 returns 0x00000010.
